// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared op encodings and signed range helpers for fxp_addacc
//
// Purpose : OP field encodings and the two's-complement max/min of a W-bit word.
// Ports   : none (package)
package fxp_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } fxp_op_e;

    function automatic logic signed [31:0] fxp_max(input int w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] fxp_min(input int w);
        return -(32'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fxp_sat.sv
// rtl/fxp_sat.sv - narrows a W+1-bit raw sum to W bits with overflow flag
//
// Purpose : signed overflow detection plus clamp (FXP_ADDACC_SAT_EN defined)
//           or modulo-2^W wrap (default build).
// Ports   : i_raw  [W:0]   raw two's-complement sum
//           o_res  [W-1:0] narrowed result
//           o_ovf          exact value not representable in W bits
// Macro   : FXP_ADDACC_SAT_EN selects clamping.
module fxp_sat
    import fxp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W:0]   i_raw,
    output logic [W-1:0] o_res,
    output logic         o_ovf
);

    // A W+1-bit sum fits in W bits exactly when its top two bits agree.
    assign o_ovf = i_raw[W] ^ i_raw[W-1];

`ifdef FXP_ADDACC_SAT_EN
    localparam logic [W-1:0] SAT_MAX = W'(fxp_max(W));
    localparam logic [W-1:0] SAT_MIN = W'(fxp_min(W));

    always_comb begin
        o_res = i_raw[W-1:0];
        if (o_ovf) begin
            o_res = i_raw[W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign o_res = i_raw[W-1:0];
`endif

endmodule

// File: rtl/fxp_addacc.sv
// rtl/fxp_addacc.sv - 2-stage signed add/sub/accumulate pipeline with handshake
//
// Purpose : stage 1 registers a W+1-bit raw sum, stage 2 narrows it through
//           fxp_sat and registers O/OVF. ACC/CLR results update the
//           accumulator; back-to-back ACC forwards the stage-2 value.
// Ports   : CLK, RESET_N (async active-low)
//           IN_VALID/IN_READY, OP[1:0], A[W-1:0], B[W-1:0]   input beat
//           OUT_VALID/OUT_READY, O[W-1:0], OVF               result
// Params  : W data width (>= 4); FRAC fraction bits (informational only)
// Macro   : FXP_ADDACC_SAT_EN clamps on overflow instead of wrapping.
module fxp_addacc
    import fxp_pkg::*;
#(
    parameter int W    = 8,
    parameter int FRAC = 7
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [1:0]   OP,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] O,
    output logic         OVF
);

    if (W < 4 || FRAC >= W || FRAC < 0) begin : g_bad_cfg
        $error("fxp_addacc: need W >= 4 and 0 <= FRAC < W");
    end

    logic         r_s1_valid;
    fxp_op_e      r_s1_op;
    logic [W:0]   r_s1_raw;
    logic         r_out_valid;
    logic [W-1:0] r_o;
    logic         r_ovf;
    logic [W-1:0] r_acc;

    logic         w_en;
    logic [W-1:0] w_sat_res;
    logic         w_sat_ovf;
    logic         w_s1_writes_acc;
    logic [W-1:0] w_acc_src;
    logic [W:0]   w_raw;
    fxp_op_e      w_op;

    assign w_en      = !r_out_valid || OUT_READY;
    assign IN_READY  = w_en;
    assign OUT_VALID = r_out_valid;
    assign O         = r_o;
    assign OVF       = r_ovf;
    assign w_op      = fxp_op_e'(OP);

    fxp_sat #(.W(W)) u_sat (
        .i_raw (r_s1_raw),
        .o_res (w_sat_res),
        .o_ovf (w_sat_ovf)
    );

    // An ACC/CLR sitting in stage 1 is about to become the accumulator on this
    // same edge, so a following ACC must use its narrowed value, not r_acc.
    assign w_s1_writes_acc = r_s1_valid && (r_s1_op == OP_ACC || r_s1_op == OP_CLR);
    assign w_acc_src       = w_s1_writes_acc ? w_sat_res : r_acc;

    always_comb begin
        w_raw = '0;
        case (w_op)
            OP_ADD:  w_raw = {A[W-1], A} + {B[W-1], B};
            OP_SUB:  w_raw = {A[W-1], A} - {B[W-1], B};
            OP_ACC:  w_raw = {w_acc_src[W-1], w_acc_src} + {A[W-1], A};
            default: w_raw = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= OP_ADD;
            r_s1_raw    <= '0;
            r_out_valid <= 1'b0;
            r_o         <= '0;
            r_ovf       <= 1'b0;
            r_acc       <= '0;
        end else if (w_en) begin
            r_s1_valid <= IN_VALID;
            if (IN_VALID) begin
                r_s1_op  <= w_op;
                r_s1_raw <= w_raw;
            end
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_o   <= w_sat_res;
                r_ovf <= w_sat_ovf;
            end
            if (w_s1_writes_acc) begin
                r_acc <= w_sat_res;
            end
        end
    end

endmodule

// File: tb/tb_fxp_addacc.sv
// tb/tb_fxp_addacc.sv - self-checking bench for fxp_addacc (W=8)
module tb_fxp_addacc;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET_N = 1'b0;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [1:0]   OP = 2'b00;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b0;
    logic [W-1:0] O;
    logic         OVF;

    fxp_addacc #(.W(W), .FRAC(7)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OP        (OP),
        .A         (A),
        .B         (B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .O         (O),
        .OVF       (OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] o;
        logic       ovf;
        int         t;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] obs_o[$];
    logic       obs_ovf[$];

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         m_acc = 0;
    logic       strict_lat = 1'b0;
    logic       hold_pending = 1'b0;
    logic [7:0] hold_o;
    logic       hold_ovf;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Exact integer arithmetic, then range test and clamp/wrap.
    function automatic void model(input logic [1:0] op, input logic [7:0] a,
                                  input logic [7:0] b, output logic [7:0] r,
                                  output logic ovf);
        int ex;
        case (op)
            2'd0:    ex = int'($signed(a)) + int'($signed(b));
            2'd1:    ex = int'($signed(a)) - int'($signed(b));
            2'd2:    ex = m_acc + int'($signed(a));
            default: ex = 0;
        endcase
        ovf = (ex > 127) || (ex < -128);
`ifdef FXP_ADDACC_SAT_EN
        if (ex > 127) ex = 127;
        else if (ex < -128) ex = -128;
`endif
        r = ex[7:0];
        if (op == 2'd2 || op == 2'd3) m_acc = int'($signed(r));
    endfunction

    task automatic cycle(input logic v, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic ordy, output logic took);
        exp_t       e;
        logic [7:0] r;
        logic       ov;
        @(negedge CLK);
        IN_VALID  = v;
        OP        = op;
        A         = a;
        B         = b;
        OUT_READY = ordy;
        #1;
        cyc++;
        if (hold_pending) begin
            chk("hold_valid", int'(OUT_VALID), 1);
            chk("hold_o", int'(O), int'(hold_o));
            chk("hold_ovf", int'(OVF), int'(hold_ovf));
        end
        chk("in_ready_rule", int'(IN_READY), int'(!OUT_VALID || OUT_READY));
        if (OUT_VALID) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", int'(OUT_VALID), 0);
            end else if (OUT_READY) begin
                e = exp_q.pop_front();
                chk("result_o", int'(O), int'(e.o));
                chk("result_ovf", int'(OVF), int'(e.ovf));
                if (strict_lat) chk("latency", cyc - e.t, 2);
                else            chk("latency_min", int'(cyc - e.t >= 2), 1);
                obs_o.push_back(O);
                obs_ovf.push_back(OVF);
            end
        end
        hold_pending = OUT_VALID && !OUT_READY;
        hold_o       = O;
        hold_ovf     = OVF;
        took = v && IN_READY;
        if (took) begin
            model(op, a, b, r, ov);
            e.o = r;
            e.ovf = ov;
            e.t = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic took;
        took = 1'b0;
        for (int i = 0; i < 50 && !took; i++) cycle(1'b1, op, a, b, 1'b1, took);
        chk("send_accepted", int'(took), 1);
    endtask

    task automatic drain();
        logic took;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycle(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, took);
        chk("drain_empty", exp_q.size(), 0);
        cycle(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, took);
    endtask

    task automatic check_obs(input string name, input logic [7:0] lo[], input logic lv[]);
        chk({name, "_count"}, obs_o.size(), lo.size());
        for (int i = 0; i < lo.size() && i < obs_o.size(); i++) begin
            chk({name, "_o"}, int'(obs_o[i]), int'(lo[i]));
            chk({name, "_ovf"}, int'(obs_ovf[i]), int'(lv[i]));
        end
    endtask

    initial begin
        logic       took;
        logic       seen_low;
        int         idx;
        logic [7:0] lo[];
        logic       lv[];
        logic [1:0] s_op[3];
        logic [7:0] s_a[3];
        logic [7:0] s_b[3];

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("reset_o", int'(O), 0);
        chk("reset_ovf", int'(OVF), 0);
        chk("reset_out_valid", int'(OUT_VALID), 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        #1;
        chk("ready_after_reset", int'(IN_READY), 1);

        // Directed, no stalls: ADD/SUB, overflow, CLR + back-to-back ACC
        strict_lat = 1'b1;
        obs_o.delete();
        obs_ovf.delete();
        send(2'd0, 8'h20, 8'h20);
        send(2'd0, 8'hE0, 8'hE0);
        send(2'd1, 8'hE0, 8'h20);
        send(2'd0, 8'h60, 8'h60);
        send(2'd0, 8'hA0, 8'hA0);
        send(2'd3, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 2'd2, 8'h20, 8'h00, 1'b1, took);
            chk("acc_no_bubble", int'(took), 1);
        end
        drain();
`ifdef FXP_ADDACC_SAT_EN
        lo = '{8'h40, 8'hC0, 8'hC0, 8'h7F, 8'h80, 8'h00, 8'h20, 8'h40, 8'h60, 8'h7F};
`else
        lo = '{8'h40, 8'hC0, 8'hC0, 8'hC0, 8'h40, 8'h00, 8'h20, 8'h40, 8'h60, 8'h80};
`endif
        lv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        check_obs("directed", lo, lv);

        // Stall: three beats offered while OUT_READY=0 for 4 cycles
        strict_lat = 1'b0;
        obs_o.delete();
        obs_ovf.delete();
        s_op = '{2'd0, 2'd1, 2'd0};
        s_a  = '{8'h10, 8'h10, 8'h7F};
        s_b  = '{8'h10, 8'h30, 8'h01};
        idx = 0;
        seen_low = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(idx < 3, s_op[idx % 3], s_a[idx % 3], s_b[idx % 3], 1'b0, took);
            if (!IN_READY) seen_low = 1'b1;
            if (took) idx++;
        end
        chk("stall_in_ready_low", int'(seen_low), 1);
        for (int i = 0; i < 20 && idx < 3; i++) begin
            cycle(1'b1, s_op[idx], s_a[idx], s_b[idx], 1'b1, took);
            if (took) idx++;
        end
        chk("stall_all_sent", idx, 3);
        drain();
`ifdef FXP_ADDACC_SAT_EN
        lo = '{8'h20, 8'hE0, 8'h7F};
`else
        lo = '{8'h20, 8'hE0, 8'h80};
`endif
        lv = '{1'b0, 1'b0, 1'b1};
        check_obs("stall", lo, lv);

        // Reset with two ACC beats in flight
        send(2'd3, 8'h00, 8'h00);
        send(2'd2, 8'h30, 8'h00);
        drain();
        cycle(1'b1, 2'd2, 8'h11, 8'h00, 1'b0, took);
        cycle(1'b1, 2'd2, 8'h11, 8'h00, 1'b0, took);
        @(negedge CLK);
        RESET_N  = 1'b0;
        IN_VALID = 1'b0;
        #1;
        chk("midreset_out_valid", int'(OUT_VALID), 0);
        chk("midreset_o", int'(O), 0);
        chk("midreset_ovf", int'(OVF), 0);
        exp_q.delete();
        m_acc = 0;
        hold_pending = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, took);
        obs_o.delete();
        obs_ovf.delete();
        send(2'd2, 8'h05, 8'h00);
        drain();
        lo = '{8'h05};
        lv = '{1'b0};
        check_obs("after_reset_acc", lo, lv);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15) + 8'h78);
            rb = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15) + 8'h78);
            cycle($urandom_range(0, 99) < 70, 2'($urandom_range(0, 3)), ra, rb,
                  $urandom_range(0, 99) < 65, took);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
